// File: rtl/fir_par_to_serial.sv
// fir_par_to_serial
//   Takes one LANES-wide block of parallel FIR results per input handshake,
//   buffers up to DEPTH blocks, and re-emits the samples one per output beat,
//   lane 0 first. The head block stays in the FIFO while it drains, so its
//   slot is released on the same edge that its last lane enters the output
//   register.
//   Optional feature macro: SAT_ROUND_EN. When it is defined, each sample is
//   rounded half-up, shifted right by FRAC_SHIFT and saturated to OUT_W bits
//   as it loads into the output register. When it is undefined, raw lane
//   values pass through unchanged.
module fir_par_to_serial #(
    parameter int LANES      = 3,
    parameter int IN_W       = 40,
    parameter int DEPTH      = 4,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_W-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [IN_W-1:0]       out_data,
    output logic [$clog2(LANES)-1:0]     out_lane,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH+1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(DEPTH);

    // Reject configurations the pointer and saturation arithmetic cannot handle.
    if (LANES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        FRAC_SHIFT < 1 || OUT_W < 2 || OUT_W > IN_W) begin : g_bad_param
        $error("fir_par_to_serial: unsupported parameter combination");
    end

`ifdef SAT_ROUND_EN
    // Half-LSB offset for round-half-up, plus saturation bounds, all at IN_W+1 bits.
    localparam logic signed [IN_W:0] RND     = (IN_W+1)'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_MAX = $signed({{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [IN_W:0] SAT_MIN = $signed({{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}});

    function automatic logic signed [IN_W-1:0] sat_round(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] shr;
        sum = $signed({x[IN_W-1], x}) + RND;
        shr = sum >>> FRAC_SHIFT;
        if (shr > SAT_MAX) begin
            shr = SAT_MAX;
        end else if (shr < SAT_MIN) begin
            shr = SAT_MIN;
        end
        // The clamped value fits in OUT_W bits, so its low IN_W bits are already sign-extended.
        return shr[IN_W-1:0];
    endfunction
`endif

    logic [LANES*IN_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LANE_W-1:0]       lane_cnt;
    logic                    wr_en;
    logic                    load;
    logic                    pop;
    logic signed [IN_W-1:0]  head_lane;
    logic signed [IN_W-1:0]  load_data;

    // in_ready depends only on occupancy, never on out_ready.
    assign in_ready = (level < DEPTH_LVL);
    assign wr_en    = in_valid && in_ready && !flush;
    assign load     = (!out_valid || out_ready) && (level != '0) && !flush;
    assign pop      = load && (lane_cnt == LAST_LANE);

    // Pick the lane of the head block that the output register loads next.
    always_comb begin
        head_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt == LANE_W'(k)) begin
                head_lane = $signed(fifo_mem[rd_ptr][k*IN_W +: IN_W]);
            end
        end
    end

`ifdef SAT_ROUND_EN
    assign load_data = sat_round(head_lane);
`else
    assign load_data = head_lane;
`endif

    // Block storage; data only, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the lane counter of the head block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            lane_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            lane_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (load) begin
                lane_cnt <= pop ? '0 : lane_cnt + LANE_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Serial output stage: holds its sample through a stall, refills on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_lane  <= lane_cnt;
            out_last  <= (lane_cnt == LAST_LANE);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_par_to_serial.sv
// Testbench for fir_par_to_serial: directed scenarios plus a randomized run,
// checked against a sample-queue reference model kept in the bench.
module tb_fir_par_to_serial;

    localparam int LANES      = 3;
    localparam int IN_W       = 40;
    localparam int DEPTH      = 4;
    localparam int OUT_W      = 16;
    localparam int FRAC_SHIFT = 15;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [IN_W-1:0] out_data;
    logic [1:0]             out_lane;
    logic                   out_last;
    logic [2:0]             level;

    int checks   = 0;
    int failures = 0;

    fir_par_to_serial #(
        .LANES(LANES), .IN_W(IN_W), .DEPTH(DEPTH), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of samples not yet in the output register, plus the register itself.
    typedef struct {
        logic signed [IN_W-1:0] d;
        int                     lane;
    } samp_t;

    samp_t pend[$];
    bit    m_vld;
    samp_t m_out;
    bit    m_acc;

    function automatic logic signed [IN_W-1:0] conv(input logic signed [IN_W-1:0] x);
`ifdef SAT_ROUND_EN
        longint v;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        v = (longint'(x) + (longint'(1) <<< (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return IN_W'(v);
`else
        return x;
`endif
    endfunction

    function automatic int m_level();
        return (pend.size() + LANES - 1) / LANES;
    endfunction

    function automatic logic signed [IN_W-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) return IN_W'($signed(r[15:0]));
        return r[IN_W-1:0];
    endfunction

    task automatic model_reset();
        pend.delete();
        m_vld      = 1'b0;
        m_out.d    = '0;
        m_out.lane = 0;
        m_acc      = 1'b0;
    endtask

    task automatic drive_blk(input logic signed [IN_W-1:0] a, input logic signed [IN_W-1:0] b,
                             input logic signed [IN_W-1:0] c);
        in_data = {c, b, a};
    endtask

    // Advance one clock and apply the same edge to the reference model.
    task automatic step();
        bit    rdy;
        bit    ld;
        samp_t s;
        @(posedge clk);
        m_acc = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            pend.delete();
            m_vld = 1'b0;
        end else begin
            rdy = (m_level() < DEPTH);
            ld  = (!m_vld || out_ready) && (pend.size() != 0);
            if (ld) begin
                m_out = pend.pop_front();
                m_vld = 1'b1;
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
            if (in_valid && rdy) begin
                for (int k = 0; k < LANES; k++) begin
                    s.d    = conv($signed(in_data[k*IN_W +: IN_W]));
                    s.lane = k;
                    pend.push_back(s);
                end
                m_acc = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_lane !== 2'd0) begin failures++; $display("FAIL reset_out_lane got=%0d exp=0", out_lane); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic signed [IN_W-1:0] b [LANES];
        b[0] = 5; b[1] = -7; b[2] = 1000;
        out_ready = 1'b1;
        drive_blk(b[0], b[1], b[2]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency got=%0b exp=0", out_valid); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL basic_level got=%0d exp=1", level); end
        for (int k = 0; k < LANES; k++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid lane=%0d got=%0b exp=1", k, out_valid); end
            checks++; if (out_data !== conv(b[k])) begin failures++; $display("FAIL basic_data lane=%0d got=%0d exp=%0d", k, out_data, conv(b[k])); end
            checks++; if (out_lane !== 2'(k)) begin failures++; $display("FAIL basic_lane got=%0d exp=%0d", out_lane, k); end
            checks++; if (out_last !== (k == LANES - 1)) begin failures++; $display("FAIL basic_last lane=%0d got=%0b", k, out_last); end
        end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle got=%0b exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL basic_level_end got=%0d exp=0", level); end
    endtask

    task automatic test_fill();
        logic signed [IN_W-1:0] b [5][LANES];
        logic signed [IN_W-1:0] e;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < LANES; k++) b[i][k] = rnd();
            drive_blk(b[i][0], b[i][1], b[i][2]);
            step();
        end
        in_valid = 1'b0;
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL fill_level got=%0d exp=4", level); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4 * LANES; i++) begin
            e = conv(b[i / LANES][i % LANES]);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_gap i=%0d got=%0b exp=1", i, out_valid); end
            checks++; if (out_data !== e) begin failures++; $display("FAIL fill_data i=%0d got=%0d exp=%0d", i, out_data, e); end
            checks++; if (out_lane !== 2'(i % LANES)) begin failures++; $display("FAIL fill_lane i=%0d got=%0d exp=%0d", i, out_lane, i % LANES); end
            if (i == 1) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_before_pop got=%0b exp=0", in_ready); end
            end
            if (i == 2) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_after_pop got=%0b exp=1", in_ready); end
                checks++; if (level !== 3'd3) begin failures++; $display("FAIL fill_level_after_pop got=%0d exp=3", level); end
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_drained got=%0b exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL fill_level_end got=%0d exp=0", level); end
    endtask

    task automatic test_random();
        int acc;
        int cyc;
        int drain;
        bit stall;
        logic signed [IN_W-1:0] pd;
        logic [1:0] pl;
        acc = 0;
        cyc = 0;
        while (acc < 100 && cyc < 5000) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            drive_blk(rnd(), rnd(), rnd());
            out_ready = ($urandom_range(0, 99) < 50);
            stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_lane;
            step();
            cyc++;
            if (m_acc) acc++;
            checks++; if (out_valid !== m_vld) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, m_vld); end
            checks++; if (level !== 3'(m_level())) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, level, m_level()); end
            checks++; if (in_ready !== (m_level() < DEPTH)) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%0b", cyc, in_ready); end
            if (m_vld) begin
                checks++; if (out_data !== m_out.d) begin failures++; $display("FAIL rand_data cyc=%0d got=%0d exp=%0d", cyc, out_data, m_out.d); end
                checks++; if (out_lane !== 2'(m_out.lane)) begin failures++; $display("FAIL rand_lane cyc=%0d got=%0d exp=%0d", cyc, out_lane, m_out.lane); end
                checks++; if (out_last !== (m_out.lane == LANES - 1)) begin failures++; $display("FAIL rand_last cyc=%0d got=%0b", cyc, out_last); end
            end
            if (stall) begin
                checks++; if (out_data !== pd || out_lane !== pl) begin failures++; $display("FAIL rand_stall cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, out_data, out_lane, pd, pl); end
            end
        end
        checks++; if (acc < 100) begin failures++; $display("FAIL rand_timeout accepted=%0d required=100", acc); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while ((m_vld || pend.size() != 0) && drain < 100) begin
            step();
            drain++;
            checks++; if (out_valid !== m_vld) begin failures++; $display("FAIL drain_valid got=%0b exp=%0b", out_valid, m_vld); end
            if (m_vld) begin
                checks++; if (out_data !== m_out.d) begin failures++; $display("FAIL drain_data got=%0d exp=%0d", out_data, m_out.d); end
            end
        end
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL drain_end valid=%0b level=%0d exp=0/0", out_valid, level); end
    endtask

    task automatic test_back_to_back();
        logic signed [IN_W-1:0] a [LANES];
        logic signed [IN_W-1:0] b [LANES];
        for (int k = 0; k < LANES; k++) begin a[k] = rnd(); b[k] = rnd(); end
        out_ready = 1'b1;
        drive_blk(a[0], a[1], a[2]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++; if (out_lane !== 2'd1 || level !== 3'd1) begin failures++; $display("FAIL b2b_setup lane=%0d level=%0d exp=1/1", out_lane, level); end
        drive_blk(b[0], b[1], b[2]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL b2b_level got=%0d exp=1", level); end
        checks++; if (out_data !== conv(a[2]) || out_lane !== 2'd2) begin failures++; $display("FAIL b2b_last got=%0d/%0d exp=%0d/2", out_data, out_lane, conv(a[2])); end
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_bubble got=%0b exp=1", out_valid); end
        checks++; if (out_data !== conv(b[0]) || out_lane !== 2'd0) begin failures++; $display("FAIL b2b_next got=%0d/%0d exp=%0d/0", out_data, out_lane, conv(b[0])); end
        repeat (3) step();
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL b2b_end valid=%0b level=%0d exp=0/0", out_valid, level); end
    endtask

    task automatic test_flush();
        logic signed [IN_W-1:0] c [LANES];
        logic signed [IN_W-1:0] e [LANES];
        for (int k = 0; k < LANES; k++) begin c[k] = rnd(); e[k] = rnd(); end
        out_ready = 1'b1;
        drive_blk(c[0], c[1], c[2]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++; if (out_lane !== 2'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL flush_setup lane=%0d valid=%0b exp=1/1", out_lane, out_valid); end
        drive_blk(rnd(), rnd(), rnd());
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
        step();
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL flush_no_accept valid=%0b level=%0d exp=0/0", out_valid, level); end
        drive_blk(e[0], e[1], e[2]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0) begin failures++; $display("FAIL flush_restart valid=%0b lane=%0d exp=1/0", out_valid, out_lane); end
        checks++; if (out_data !== conv(e[0])) begin failures++; $display("FAIL flush_restart_data got=%0d exp=%0d", out_data, conv(e[0])); end
        step();
        step();
        checks++; if (out_data !== conv(e[2]) || out_last !== 1'b1) begin failures++; $display("FAIL flush_tail got=%0d/%0b exp=%0d/1", out_data, out_last, conv(e[2])); end
        step();
    endtask

    task automatic test_sat_round();
        logic signed [IN_W-1:0] b [LANES];
        logic signed [IN_W-1:0] x [LANES];
        b[0] = 114688;
        b[1] = 40'sd1 <<< 30;
        b[2] = -(40'sd1 <<< 31);
`ifdef SAT_ROUND_EN
        x[0] = 4; x[1] = 32767; x[2] = -32768;
`else
        x[0] = b[0]; x[1] = b[1]; x[2] = b[2];
`endif
        out_ready = 1'b1;
        drive_blk(b[0], b[1], b[2]);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            step();
            checks++; if (out_data !== x[k] || out_valid !== 1'b1) begin failures++; $display("FAIL sat_lane%0d got=%0d exp=%0d", k, out_data, x[k]); end
        end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive_blk(rnd(), rnd(), rnd());
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_setup got=%0b exp=1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL rmid_async valid=%0b level=%0d exp=0/0", out_valid, level); end
        checks++; if (out_data !== '0 || out_lane !== 2'd0) begin failures++; $display("FAIL rmid_outputs data=%0d lane=%0d exp=0/0", out_data, out_lane); end
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL rmid_no_resume valid=%0b level=%0d exp=0/0", out_valid, level); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_flush();
        test_sat_round();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
